led_ring_driver: RTL and testbench

//   Downstream of the quadrature encoder stage: takes its 6-bit position (0..36)
//   and displays it as a bar graph on the LED ring of the LED-Encoder breakout.
//   The ring is driven through chained 74HC595 shift registers (SER/SRCLK/RCLK/OE_n).

---
 rtl/led_ring_driver.sv | 172 +++++++++++++++++
 tb/tb_led_ring_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_ring_driver.sv
// led_ring_driver
// Turns a clamped encoder position into a bar-graph frame and shifts it out to a
// chain of 74HC595 shift registers. A frame is sent whenever the displayed value
// differs from the input, on a periodic refresh, and once after every reset.
// The 595 outputs stay disabled until the first frame has been latched.
module led_ring_driver #(
  parameter int NUM_LEDS       = 24,
  parameter int MAX_VALUE      = 36,
  parameter int SCLK_DIV       = 25,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] value,
  output logic       led_ser,
  output logic       led_srclk,
  output logic       led_rclk,
  output logic       led_oe_n,
  output logic       busy,
  output logic       frame_done
);

  localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int PROD_W = 16;

  localparam logic [5:0]       MAX_V    = 6'(MAX_VALUE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SHIFT_LO = 2'd1;
  localparam logic [1:0] S_SHIFT_HI = 2'd2;
  localparam logic [1:0] S_LATCH    = 2'd3;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_bit_idx;
  logic [5:0]       r_snap;
  logic [5:0]       r_shown;
  logic             r_shown_valid;
  logic [REF_W-1:0] r_ref_cnt;
  logic             r_ref_pending;
  logic             r_ser;
  logic             r_srclk;
  logic             r_rclk;
  logic             r_oe_n;
  logic             r_busy;
  logic             r_frame_done;

  logic [5:0] w_v;
  logic       w_div_last;
  logic       w_start;

  // LED idx is lit when v*NUM_LEDS >= (idx+1)*MAX_VALUE; constant multiplies only.
  function automatic logic led_lit(input logic [5:0] v, input logic [IDX_W-1:0] idx);
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    lhs = PROD_W'(v) * PROD_W'(NUM_LEDS);
    rhs = (PROD_W'(idx) + PROD_W'(1)) * PROD_W'(MAX_VALUE);
    return lhs >= rhs;
  endfunction

  assign w_v        = (value > MAX_V) ? MAX_V : value;
  assign w_div_last = (r_div == DIV_LAST);
  assign w_start    = (r_state == S_IDLE) &&
                      (!r_shown_valid || (w_v != r_shown) || r_ref_pending);

  // Frame sequencer: pacing divider, bit index and all registered 595 pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_bit_idx     <= '0;
      r_snap        <= '0;
      r_shown       <= '0;
      r_shown_valid <= 1'b0;
      r_ser         <= 1'b0;
      r_srclk       <= 1'b0;
      r_rclk        <= 1'b0;
      r_oe_n        <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch reads the pre-edge
      // register values regardless of statement order.
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_start) begin
            // The first bit comes straight from w_v because r_snap is loaded on this edge.
            r_snap    <= w_v;
            r_bit_idx <= LAST_IDX;
            r_ser     <= led_lit(w_v, LAST_IDX);
            r_srclk   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_srclk <= 1'b1;
            r_state <= S_SHIFT_HI;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT_HI: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_srclk <= 1'b0;
            if (r_bit_idx == '0) begin
              r_rclk  <= 1'b1;
              r_state <= S_LATCH;
            end else begin
              r_bit_idx <= r_bit_idx - IDX_W'(1);
              r_ser     <= led_lit(r_snap, r_bit_idx - IDX_W'(1));
              r_state   <= S_SHIFT_LO;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin // S_LATCH
          if (w_div_last) begin
            r_div         <= '0;
            r_rclk        <= 1'b0;
            r_shown       <= r_snap;
            r_shown_valid <= 1'b1;
            r_oe_n        <= 1'b0;
            r_frame_done  <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
      endcase
    end
  end

  // Refresh timer: free-running in every state, restarted whenever a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else if (REFRESH_CYCLES == 0) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else if (w_start) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  assign led_ser    = r_ser;
  assign led_srclk  = r_srclk;
  assign led_rclk   = r_rclk;
  assign led_oe_n   = r_oe_n;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_ring_driver.sv
// tb_led_ring_driver
// Directed bench for led_ring_driver. Instance u_dut (refresh disabled) runs the
// directed sequence against a scoreboard of expected frames; instance u_dut_ref
// (refresh every 200 cycles, constant value 9) checks the periodic re-send.
module tb_led_ring_driver;

  logic       clk;
  logic       rst_n, rst_b;
  logic [5:0] value, value_b;
  logic       ser, srclk, rclk, oe_n, busy, frame_done;
  logic       ser_b, srclk_b, rclk_b, oe_n_b, busy_b, frame_done_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [23:0] exp_q[$];

  led_ring_driver #(.NUM_LEDS(24), .MAX_VALUE(36), .SCLK_DIV(2), .REFRESH_CYCLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value),
    .led_ser(ser), .led_srclk(srclk), .led_rclk(rclk), .led_oe_n(oe_n),
    .busy(busy), .frame_done(frame_done)
  );

  led_ring_driver #(.NUM_LEDS(24), .MAX_VALUE(36), .SCLK_DIV(2), .REFRESH_CYCLES(200)) u_dut_ref (
    .clk(clk), .rst_n(rst_b), .value(value_b),
    .led_ser(ser_b), .led_srclk(srclk_b), .led_rclk(rclk_b), .led_oe_n(oe_n_b),
    .busy(busy_b), .frame_done(frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor for u_dut ----------------
  logic        p_srclk = 1'b0, p_busy = 1'b0;
  logic [23:0] sr = '0;
  int          bits = 0, rclk_hi = 0, start_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sr = '0; bits = 0; rclk_hi = 0;
    end else begin
      if (busy && !p_busy) begin
        start_cyc = cyc; sr = '0; bits = 0; rclk_hi = 0;
      end
      if (srclk && !p_srclk) begin
        sr = {sr[22:0], ser};
        bits++;
      end
      if (rclk) rclk_hi++;
      if (frame_done) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("frame_bits", 32'(sr), 32'(exp_q.pop_front()));
        check("srclk_rises", 32'(bits), 32'd24);
        check("rclk_high_cycles", 32'(rclk_hi), 32'd2);
        check("frame_length", 32'(cyc - start_cyc), 32'd98);
        check("oe_n_after_latch", 32'(oe_n), 32'd0);
      end
    end
    p_srclk = srclk;
    p_busy  = busy;
  end

  // ---------------- monitor for u_dut_ref ----------------
  logic        pb_srclk = 1'b0, pb_busy = 1'b0;
  logic [23:0] sr_b = '0;
  int          frames_b = 0, last_start_b = -1;

  always @(negedge clk) begin
    if (rst_b) begin
      if (busy_b && !pb_busy) begin
        if (last_start_b >= 0)
          check("refresh_period", 32'(((cyc - last_start_b) == 200) || ((cyc - last_start_b) == 201)), 32'd1);
        last_start_b = cyc;
        sr_b = '0;
      end
      if (srclk_b && !pb_srclk) sr_b = {sr_b[22:0], ser_b};
      if (frame_done_b) begin
        check("refresh_frame_bits", 32'(sr_b), 32'h00003F);
        frames_b++;
      end
    end
    pb_srclk = srclk_b;
    pb_busy  = busy_b;
  end

  // Waits (bounded) for frame_done on u_dut; leaves time at that negedge.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_seen"}, 32'(busy), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; rst_b = 1'b0;
    value = 6'd18; value_b = 6'd9;
    repeat (3) @(negedge clk);
    check("rst_ser",        32'(ser),        32'd0);
    check("rst_srclk",      32'(srclk),      32'd0);
    check("rst_rclk",       32'(rclk),       32'd0);
    check("rst_oe_n",       32'(oe_n),       32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // First frame after reset: value 18 lights LEDs 0..11.
    exp_q.push_back(24'h000FFF);
    rst_n = 1'b1; rst_b = 1'b1;
    repeat (50) @(negedge clk);
    check("first_frame_busy", 32'(busy), 32'd1);
    check("first_frame_oe_n", 32'(oe_n), 32'd1);
    wait_done("f18");
    @(negedge clk);
    check("no_restart_same_value", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("idle_stays_idle", 32'(busy), 32'd0);

    // Full scale, empty, and over-range clamp.
    value = 6'd36; exp_q.push_back(24'hFFFFFF); wait_busy("f36"); wait_done("f36");
    @(negedge clk);
    value = 6'd0;  exp_q.push_back(24'h000000); wait_busy("f0");  wait_done("f0");
    @(negedge clk);
    value = 6'd50; exp_q.push_back(24'hFFFFFF); wait_busy("f50"); wait_done("f50");
    @(negedge clk);
    value = 6'd36;
    repeat (20) @(negedge clk);
    check("clamp_50_eq_36_no_frame", 32'(busy), 32'd0);

    // Change mid-frame: snapshot used, follow-up frame right after frame_done.
    value = 6'd18; exp_q.push_back(24'h000FFF);
    wait_busy("mid");
    repeat (10) @(negedge clk);
    value = 6'd24; exp_q.push_back(24'h00FFFF);
    wait_done("mid_first");
    check("gap_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    check("restart_next_cycle", 32'(busy), 32'd1);
    wait_done("mid_second");
    @(negedge clk);

    // Reset during SHIFT_HI: the partial frame is discarded.
    value = 6'd36;
    begin
      int n = 0;
      while (!srclk && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("pre_rst_srclk", 32'(srclk), 32'd1);
    check("pre_rst_ser",   32'(ser),   32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_srclk", 32'(srclk), 32'd0);
    check("midrst_ser",   32'(ser),   32'd0);
    check("midrst_rclk",  32'(rclk),  32'd0);
    check("midrst_oe_n",  32'(oe_n),  32'd1);
    check("midrst_busy",  32'(busy),  32'd0);
    repeat (3) @(negedge clk);
    exp_q.push_back(24'hFFFFFF);
    rst_n = 1'b1;
    wait_busy("after_rst");
    check("after_rst_oe_n", 32'(oe_n), 32'd1);
    wait_done("after_rst");
    @(negedge clk);
    repeat (5) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("refresh_frames_min", 32'(frames_b >= 4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
